// File: rtl/time_digit_register_if.sv
// Bus bundle for time_digit_register: keypad/control inputs and the
// digit/status outputs. Member suffixes are relative to the design
// (slave) side: _i is driven into the design, _o is driven by it.
interface time_digit_register_if;
    logic       load_i;
    logic [3:0] key_code_i;
    logic       clear_i;
    logic       start_i;
    logic       done_i;
    logic [3:0] min_tens_o;
    logic [3:0] min_units_o;
    logic [3:0] sec_tens_o;
    logic [3:0] sec_units_o;
    logic [2:0] digit_count_o;
    logic       full_o;
    logic       locked_o;
    logic       start_pulse_o;

    // Driver side: produces the key/control events, observes the digits.
    modport master (
        output load_i, key_code_i, clear_i, start_i, done_i,
        input  min_tens_o, min_units_o, sec_tens_o, sec_units_o,
               digit_count_o, full_o, locked_o, start_pulse_o
    );

    // Design side.
    modport slave (
        input  load_i, key_code_i, clear_i, start_i, done_i,
        output min_tens_o, min_units_o, sec_tens_o, sec_units_o,
               digit_count_o, full_o, locked_o, start_pulse_o
    );
endinterface

// File: rtl/time_digit_register.sv
// time_digit_register: keypad digit-entry stage for the MM:SS timer.
// Each valid load strobe shifts a BCD key into the four-digit register
// from the right; start locks the entered time for the countdown.
// Per-cycle event priority is clear > done > start > load; the highest
// asserted event is the only one considered.
// Optional feature: define SECONDS_CLAMP_EN to clamp sec_tens > 5 to 59
// seconds on the lock transition. Default build leaves digits unchanged.
module time_digit_register (
    input  logic                  clock_i,
    input  logic                  reset_i,
    time_digit_register_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ENTRY  = 2'b01,
        FULL   = 2'b10,
        LOCKED = 2'b11
    } state_t;

    state_t     state_q,      state_d;
    logic [3:0] min_tens_q,   min_tens_d;
    logic [3:0] min_units_q,  min_units_d;
    logic [3:0] sec_tens_q,   sec_tens_d;
    logic [3:0] sec_units_q,  sec_units_d;
    logic [2:0] count_q,      count_d;
    logic       pulse_q,      pulse_d;
    logic       key_valid;

    assign key_valid = (bus.key_code_i <= 4'd9);

    // State register plus digit/count/pulse registers, async reset to empty.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= EMPTY;
            min_tens_q  <= 4'd0;
            min_units_q <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_units_q <= 4'd0;
            count_q     <= 3'd0;
            pulse_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_tens_q  <= min_tens_d;
            min_units_q <= min_units_d;
            sec_tens_q  <= sec_tens_d;
            sec_units_q <= sec_units_d;
            count_q     <= count_d;
            pulse_q     <= pulse_d;
        end
    end

    // Next-state and datapath update, resolving events by priority.
    always_comb begin
        state_d     = state_q;
        min_tens_d  = min_tens_q;
        min_units_d = min_units_q;
        sec_tens_d  = sec_tens_q;
        sec_units_d = sec_units_q;
        count_d     = count_q;
        pulse_d     = 1'b0;
        if (bus.clear_i) begin
            state_d     = EMPTY;
            min_tens_d  = 4'd0;
            min_units_d = 4'd0;
            sec_tens_d  = 4'd0;
            sec_units_d = 4'd0;
            count_d     = 3'd0;
        end else if (bus.done_i) begin
            // done outside LOCKED is a no-op but still masks start/load.
            if (state_q == LOCKED) begin
                state_d     = EMPTY;
                min_tens_d  = 4'd0;
                min_units_d = 4'd0;
                sec_tens_d  = 4'd0;
                sec_units_d = 4'd0;
                count_d     = 3'd0;
            end
        end else if (bus.start_i) begin
            // A key arriving together with start is dropped.
            if (state_q == ENTRY || state_q == FULL) begin
                state_d = LOCKED;
                pulse_d = 1'b1;
`ifdef SECONDS_CLAMP_EN
                if (sec_tens_q > 4'd5) begin
                    sec_tens_d  = 4'd5;
                    sec_units_d = 4'd9;
                end
`endif
            end
        end else if (bus.load_i && key_valid) begin
            // Leading zeros in EMPTY are not counted as digits.
            if ((state_q == EMPTY && bus.key_code_i != 4'd0) || state_q == ENTRY) begin
                min_tens_d  = min_units_q;
                min_units_d = sec_tens_q;
                sec_tens_d  = sec_units_q;
                sec_units_d = bus.key_code_i;
                count_d     = count_q + 3'd1;
                state_d     = (count_q == 3'd3) ? FULL : ENTRY;
            end
        end
    end

    // Output decode from registered state and registers.
    always_comb begin
        bus.min_tens_o    = min_tens_q;
        bus.min_units_o   = min_units_q;
        bus.sec_tens_o    = sec_tens_q;
        bus.sec_units_o   = sec_units_q;
        bus.digit_count_o = count_q;
        bus.full_o        = (state_q == FULL);
        bus.locked_o      = (state_q == LOCKED);
        bus.start_pulse_o = pulse_q;
    end
endmodule
